key_repeat: RTL and testbench

KEY_REPEAT -- requirements
Module: key_repeat

---
 rtl/key_repeat_pkg.sv | 13 +
 rtl/key_repeat.sv | 99 +++++++++
 tb/tb_key_repeat.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_repeat_pkg.sv
// Shared definitions for the key auto-repeat block: FSM state encoding and
// tick-counter width.
package key_repeat_pkg;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

endpackage

// File: rtl/key_repeat.sv
// Key auto-repeat: one pulse on press, a second after DELAY_TICKS ticks, then
// one every RATE_TICKS ticks while held; counts pulses per hold (saturating).
module key_repeat
    import key_repeat_pkg::*;
#(
    parameter int unsigned DELAY_TICKS = 500,
    parameter int unsigned RATE_TICKS  = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       key_in,
    output logic       pulse_out,
    output logic       repeating,
    output logic [7:0] pulse_cnt
);

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_TICKS - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_TICKS - 1);

    state_e           state_q;
    logic [CNT_W-1:0] tcnt_q;
    logic             pulse_q;
    logic             repeating_q;
    logic [7:0]       pulse_cnt_q;
    logic [7:0]       pulse_cnt_d;

    // Saturating increment used for every repeat pulse.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (pulse_cnt_q != 8'hFF) begin
            pulse_cnt_d = pulse_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tcnt_q      <= '0;
            pulse_q     <= 1'b0;
            repeating_q <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (key_in) begin
                        state_q     <= ST_WAIT;
                        tcnt_q      <= '0;
                        pulse_q     <= 1'b1;
                        pulse_cnt_q <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    // Release takes priority over a coincident terminal tick.
                    if (!key_in) begin
                        state_q <= ST_IDLE;
                        tcnt_q  <= '0;
                    end else if (tick) begin
                        if (tcnt_q == DELAY_LAST) begin
                            state_q     <= ST_REPEAT;
                            repeating_q <= 1'b1;
                            tcnt_q      <= '0;
                            pulse_q     <= 1'b1;
                            pulse_cnt_q <= pulse_cnt_d;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!key_in) begin
                        state_q     <= ST_IDLE;
                        repeating_q <= 1'b0;
                        tcnt_q      <= '0;
                    end else if (tick) begin
                        if (tcnt_q == RATE_LAST) begin
                            tcnt_q      <= '0;
                            pulse_q     <= 1'b1;
                            pulse_cnt_q <= pulse_cnt_d;
                        end else begin
                            tcnt_q <= tcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    repeating_q <= 1'b0;
                    tcnt_q      <= '0;
                end
            endcase
        end
    end

    assign pulse_out = pulse_q;
    assign repeating = repeating_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_key_repeat.sv
// Self-checking bench for key_repeat (DELAY_TICKS=3, RATE_TICKS=2): table
// vectors, directed multi-cycle sequences and random stimulus vs a hold model.
module tb_key_repeat;

    localparam int DELAY = 3;
    localparam int RATE  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       key_in = 1'b0;
    logic       pulse_out;
    logic       repeating;
    logic [7:0] pulse_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: describes a hold in terms of pulses emitted so far and
    // ticks elapsed since the latest pulse.
    bit m_hold;
    int m_ticks;
    int m_n;
    bit m_pulse;

    typedef struct {
        logic       key;
        logic       tck;
        logic       exp_pulse;
        logic       exp_rep;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t tbl[17];

    key_repeat #(.DELAY_TICKS(DELAY), .RATE_TICKS(RATE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .key_in   (key_in),
        .pulse_out(pulse_out),
        .repeating(repeating),
        .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_cnt();
        return (m_n > 255) ? 255 : m_n;
    endfunction

    function automatic bit m_rep();
        return m_hold && (m_n >= 2);
    endfunction

    task automatic model_reset();
        m_hold  = 1'b0;
        m_ticks = 0;
        m_n     = 0;
        m_pulse = 1'b0;
    endtask

    task automatic model_edge(input logic k, input logic t);
        int need;
        m_pulse = 1'b0;
        if (!m_hold) begin
            if (k) begin
                m_hold  = 1'b1;
                m_n     = 1;
                m_ticks = 0;
                m_pulse = 1'b1;
            end
        end else if (!k) begin
            m_hold = 1'b0;
        end else if (t) begin
            m_ticks++;
            need = (m_n == 1) ? DELAY : RATE;
            if (m_ticks == need) begin
                m_ticks = 0;
                m_n++;
                m_pulse = 1'b1;
            end
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pulse"}, int'(pulse_out), int'(m_pulse));
        chk({tag, ".rep"},   int'(repeating), int'(m_rep()));
        chk({tag, ".cnt"},   int'(pulse_cnt), m_cnt());
    endtask

    // Applies one cycle of inputs, advances the model and samples 1ns after the edge.
    task automatic step(input logic k, input logic t);
        @(negedge clk);
        key_in = k;
        tick   = t;
        @(posedge clk);
        model_edge(k, t);
        #1;
    endtask

    initial begin
        int pulses;
        int prev;
        int cyc;
        int first_pulse_ok;
        int b2b;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd2};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd2};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd3};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd3};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd3};

        model_reset();
        #12;
        chk("reset.pulse", int'(pulse_out), 0);
        chk("reset.rep",   int'(repeating), 0);
        chk("reset.cnt",   int'(pulse_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Short press, release on terminal WAIT tick, short repeat run.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].key, tbl[i].tck);
            chk($sformatf("tbl%0d.pulse", i), int'(pulse_out), int'(tbl[i].exp_pulse));
            chk($sformatf("tbl%0d.rep", i),   int'(repeating), int'(tbl[i].exp_rep));
            chk($sformatf("tbl%0d.cnt", i),   int'(pulse_cnt), int'(tbl[i].exp_cnt));
        end

        // 40-clk hold, tick every 4th clk: pulses after edges 0, 11, 19, 27, 35.
        pulses = 0;
        first_pulse_ok = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (i % 4) == 3);
            chk_model("hold40");
            if (pulse_out) pulses++;
            if (i == 0) first_pulse_ok = int'(pulse_out);
            if (i == 10) chk("hold40.rep_before", int'(repeating), 0);
            if (i == 11) begin
                chk("hold40.second_pulse", int'(pulse_out), 1);
                chk("hold40.rep_after", int'(repeating), 1);
            end
        end
        chk("hold40.first_pulse", first_pulse_ok, 1);
        chk("hold40.pulses", pulses, 5);
        chk("hold40.cnt", int'(pulse_cnt), 5);
        step(1'b0, 1'b0);
        chk_model("hold40.rel");
        chk("hold40.cnt_after_rel", int'(pulse_cnt), 5);

        // Saturation: tick every clk until 300 pulses, bounded.
        pulses = 0;
        prev = 0;
        b2b = 0;
        cyc = 0;
        while (pulses < 300 && cyc < 2000) begin
            step(1'b1, 1'b1);
            chk_model("sat");
            if (pulse_out) pulses++;
            if (pulse_out && prev == 1) b2b++;
            prev = int'(pulse_out);
            cyc++;
        end
        chk("sat.pulses", pulses, 300);
        chk("sat.back_to_back", b2b, 0);
        chk("sat.cnt", int'(pulse_cnt), 255);
        chk("sat.rep", int'(repeating), 1);
        step(1'b0, 1'b0);
        chk_model("sat.rel");

        // Asynchronous reset mid-REPEAT with key still held.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1);
            chk_model("prerst");
        end
        chk("prerst.rep", int'(repeating), 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst.pulse", int'(pulse_out), 0);
        chk("rst.rep",   int'(repeating), 0);
        chk("rst.cnt",   int'(pulse_cnt), 0);
        #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0);
        chk("postrst.pulse", int'(pulse_out), 1);
        chk("postrst.cnt",   int'(pulse_cnt), 1);
        chk_model("postrst");
        step(1'b0, 1'b0);
        chk_model("postrst.rel");

        // Tick frozen for 100 clks while held; then exactly 3 ticks produce the next pulse.
        step(1'b1, 1'b0);
        chk_model("frz.press");
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0);
            chk_model("frz");
            if (pulse_out) pulses++;
        end
        chk("frz.pulses", pulses, 0);
        chk("frz.rep", int'(repeating), 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("frz.tick2", int'(pulse_out), 0);
        step(1'b1, 1'b1);
        chk("frz.tick3", int'(pulse_out), 1);
        chk_model("frz.tick3");
        step(1'b0, 1'b0);
        chk_model("frz.rel");

        // Random holds and ticks against the model.
        for (int i = 0; i < 3000; i++) begin
            logic k;
            logic t;
            k = key_in;
            if ($urandom_range(0, 15) == 0) k = ~k;
            t = ($urandom_range(0, 2) == 0);
            step(k, t);
            chk_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
